lcd_driver: RTL

Responder end of the character-display handshake. It accepts one byte at a time from the sequencing controller via data_ready/lcd_busy and drives an HD44780-compatible character LCD over an 8-bit parallel bus. After reset it runs the power-on initialisation sequence with lcd_busy held high. It then services character writes, keeping lcd_busy high for each complete bus transaction, including the execution wait.

---
 rtl/lcd_driver.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_driver.sv
// lcd_driver: responder end of the character-display handshake.
// Runs the HD44780 power-on initialisation, then writes one byte per
// data_ready request over an 8-bit parallel bus, holding lcd_busy high for
// the full bus transaction including the execution wait.
// Optional feature macro: LCD_LINE_WRAP_EN (automatic line wrap after 16 chars).
`timescale 1ns/1ps

module lcd_driver #(
    parameter int unsigned POWER_ON_CYCLES   = 750000,
    parameter int unsigned INIT_WAIT_CYCLES  = 205000,
    parameter int unsigned SETUP_CYCLES      = 4,
    parameter int unsigned E_PULSE_CYCLES    = 12,
    parameter int unsigned CMD_WAIT_CYCLES   = 2000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clock,
    input  logic       internal_reset_n,
    input  logic [7:0] data_in,
    input  logic       data_ready,
    output logic       lcd_busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e
);

    localparam int unsigned CNT_W    = 20;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned COL_W    = 5;
    localparam int unsigned INIT_LAST = 6;

    typedef enum logic [2:0] {
        S_POWER_WAIT,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC_WAIT,
        S_IDLE
    } state_t;

    // What the current bus transaction belongs to; selects the exec wait
    // and what happens once it completes.
    typedef enum logic [1:0] {
        M_INIT,
        M_CHAR,
        M_WRAP
    } mode_t;

    state_t             state_q;
    mode_t              mode_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [IDX_W-1:0]   init_idx_q;
    logic [IDX_W-1:0]   init_idx_d;
    logic [CNT_W-1:0]   exec_last_c;
    logic [CNT_W-1:0]   phase_last_c;
    logic               phase_done_c;
`ifdef LCD_LINE_WRAP_EN
    logic [COL_W-1:0]   col_q;
    logic               line_q;
`endif

    // Init command table: function set x4, display on, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [IDX_W-1:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: init_cmd = 8'h38;
            3'd4:                   init_cmd = 8'h0C;
            3'd5:                   init_cmd = 8'h01;
            3'd6:                   init_cmd = 8'h06;
            default:                init_cmd = 8'h00;
        endcase
    endfunction

    // Exec wait for the transaction in flight: first function-set and
    // clear display need the long waits, everything else the normal one.
    always_comb begin
        exec_last_c = CNT_W'(CMD_WAIT_CYCLES - 1);
        if (mode_q == M_INIT) begin
            if (init_idx_q == 3'd0) begin
                exec_last_c = CNT_W'(INIT_WAIT_CYCLES - 1);
            end else if (init_idx_q == 3'd5) begin
                exec_last_c = CNT_W'(CLEAR_WAIT_CYCLES - 1);
            end
        end
    end

    // Terminal count of the current phase; a count of N gives N cycles.
    always_comb begin
        phase_last_c = '0;
        case (state_q)
            S_POWER_WAIT: phase_last_c = CNT_W'(POWER_ON_CYCLES - 1);
            S_SETUP:      phase_last_c = CNT_W'(SETUP_CYCLES - 1);
            S_PULSE:      phase_last_c = CNT_W'(E_PULSE_CYCLES - 1);
            S_HOLD:       phase_last_c = CNT_W'(SETUP_CYCLES - 1);
            S_EXEC_WAIT:  phase_last_c = exec_last_c;
            default:      phase_last_c = '0;
        endcase
        phase_done_c = (cnt_q == phase_last_c);
        cnt_d        = cnt_q + CNT_W'(1);
        init_idx_d   = init_idx_q + IDX_W'(1);
    end

    // Sequencer: phase timing, init table walk, character writes, wraps.
    always_ff @(posedge clock) begin
        lcd_rw <= 1'b0;
        if (!internal_reset_n) begin
            state_q    <= S_POWER_WAIT;
            mode_q     <= M_INIT;
            cnt_q      <= '0;
            init_idx_q <= '0;
            lcd_busy   <= 1'b1;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
`ifdef LCD_LINE_WRAP_EN
            col_q      <= '0;
            line_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_POWER_WAIT: begin
                    if (phase_done_c) begin
                        cnt_q      <= '0;
                        init_idx_q <= '0;
                        mode_q     <= M_INIT;
                        lcd_rs     <= 1'b0;
                        lcd_data   <= init_cmd(3'd0);
                        state_q    <= S_SETUP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_SETUP: begin
                    if (phase_done_c) begin
                        cnt_q   <= '0;
                        lcd_e   <= 1'b1;
                        state_q <= S_PULSE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_PULSE: begin
                    if (phase_done_c) begin
                        cnt_q   <= '0;
                        lcd_e   <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_HOLD: begin
                    if (phase_done_c) begin
                        cnt_q   <= '0;
                        state_q <= S_EXEC_WAIT;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_EXEC_WAIT: begin
                    if (phase_done_c) begin
                        cnt_q <= '0;
                        case (mode_q)
                            M_INIT: begin
                                if (init_idx_q == IDX_W'(INIT_LAST)) begin
                                    lcd_busy <= 1'b0;
                                    state_q  <= S_IDLE;
                                end else begin
                                    init_idx_q <= init_idx_d;
                                    lcd_rs     <= 1'b0;
                                    lcd_data   <= init_cmd(init_idx_d);
                                    state_q    <= S_SETUP;
                                end
                            end
                            M_CHAR: begin
`ifdef LCD_LINE_WRAP_EN
                                if (col_q == COL_W'(15)) begin
                                    // 16th char of a line: move the cursor
                                    // to the start of the other line.
                                    col_q    <= '0;
                                    line_q   <= ~line_q;
                                    lcd_rs   <= 1'b0;
                                    lcd_data <= line_q ? 8'h80 : 8'hC0;
                                    mode_q   <= M_WRAP;
                                    state_q  <= S_SETUP;
                                end else begin
                                    col_q    <= col_q + COL_W'(1);
                                    lcd_busy <= 1'b0;
                                    state_q  <= S_IDLE;
                                end
`else
                                lcd_busy <= 1'b0;
                                state_q  <= S_IDLE;
`endif
                            end
                            default: begin
                                lcd_busy <= 1'b0;
                                state_q  <= S_IDLE;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_IDLE: begin
                    cnt_q <= '0;
                    if (data_ready) begin
                        lcd_data <= data_in;
                        lcd_rs   <= 1'b1;
                        lcd_busy <= 1'b1;
                        mode_q   <= M_CHAR;
                        state_q  <= S_SETUP;
                    end
                end
                default: begin
                    cnt_q    <= '0;
                    lcd_e    <= 1'b0;
                    lcd_busy <= 1'b1;
                    state_q  <= S_POWER_WAIT;
                end
            endcase
        end
    end

endmodule
